reg_fetch_fwd: RTL and testbench

- Register-fetch/forwarding (RF/FWD) stage directly upstream of the simple fixed-point execute pipe.
- Holds the SPU 128-entry x 128-bit register file and takes the write-back port from the execute pipe.
- Reads two source operands, bypassing in-flight results, and registers the decoded fields and operand values (op, format, rt_addr, ra, rb, imm, reg_write) that feed the execute pipe on the next cycle.
- Supports stall (hold with operand refresh) and flush (inject nop).

---
 rtl/reg_fetch_fwd.sv | 86 ++++++++
 tb/tb_reg_fetch_fwd.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/reg_fetch_fwd.sv
// reg_fetch_fwd: 128x128 register file with fwd/wb bypass, registering decoded fields and operands for execute.
module reg_fetch_fwd #(
  parameter int NUM_REGS = 128,
  parameter int WIDTH    = 128,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [10:0]       op_in,
  input  logic [2:0]        format_in,
  input  logic [ADDR_W-1:0] rt_addr_in,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic [17:0]       imm_in,
  input  logic              reg_write_in,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_en,
  input  logic [WIDTH-1:0]  fwd_data,
  input  logic [ADDR_W-1:0] fwd_addr,
  input  logic              fwd_en,
  output logic [10:0]       op,
  output logic [2:0]        format,
  output logic [ADDR_W-1:0] rt_addr,
  output logic [WIDTH-1:0]  ra,
  output logic [WIDTH-1:0]  rb,
  output logic [17:0]       imm,
  output logic              reg_write
);
  logic [WIDTH-1:0]  regs_q [NUM_REGS];
  logic [10:0]       op_q;
  logic [2:0]        format_q;
  logic [ADDR_W-1:0] rt_q, ra_q, rb_q, src_a, src_b;
  logic [WIDTH-1:0]  opa_q, opb_q, opa_d, opb_d;
  logic [17:0]       imm_q;
  logic              rw_q;
  // While stalled, operands are re-read from the held source addresses so late results are picked up.
  always_comb begin
    src_a = stall ? ra_q : ra_addr;
    src_b = stall ? rb_q : rb_addr;
    opa_d = (fwd_en && fwd_addr == src_a) ? fwd_data : (wb_en && wb_addr == src_a) ? wb_data : regs_q[src_a];
    opb_d = (fwd_en && fwd_addr == src_b) ? fwd_data : (wb_en && wb_addr == src_b) ? wb_data : regs_q[src_b];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[wb_addr] <= wb_data;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      op_q     <= '0;
      format_q <= '0;
      rt_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      imm_q    <= '0;
      rw_q     <= 1'b0;
    end else if (stall) begin
      opa_q <= opa_d;
      opb_q <= opb_d;
    end else begin
      op_q     <= op_in;
      format_q <= format_in;
      rt_q     <= rt_addr_in;
      ra_q     <= ra_addr;
      rb_q     <= rb_addr;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      imm_q    <= imm_in;
      rw_q     <= reg_write_in;
    end
  end
  assign op        = op_q;
  assign format    = format_q;
  assign rt_addr   = rt_q;
  assign ra        = opa_q;
  assign rb        = opb_q;
  assign imm       = imm_q;
  assign reg_write = rw_q;
endmodule

// File: tb/tb_reg_fetch_fwd.sv
// tb_reg_fetch_fwd: scenario tasks with a reference model feeding an expected-output queue.
module tb_reg_fetch_fwd;
  typedef struct packed {
    logic [10:0]  op;
    logic [2:0]   fmt;
    logic [6:0]   rt;
    logic [127:0] ra;
    logic [127:0] rb;
    logic [17:0]  imm;
    logic         rw;
  } out_t;

  logic clk = 0, reset, stall, flush, reg_write_in, wb_en, fwd_en;
  logic [10:0] op_in;
  logic [2:0] format_in;
  logic [6:0] rt_addr_in, ra_addr, rb_addr, wb_addr, fwd_addr;
  logic [17:0] imm_in;
  logic [127:0] wb_data, fwd_data;
  logic [10:0] op;
  logic [2:0] format;
  logic [6:0] rt_addr;
  logic [127:0] ra, rb;
  logic [17:0] imm;
  logic reg_write;
  out_t dout, e, m_out;
  logic [127:0] mregs [128];
  logic [6:0] m_ra, m_rb;
  out_t sb [$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  assign dout = {op, format, rt_addr, ra, rb, imm, reg_write};

  reg_fetch_fwd dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .op_in(op_in), .format_in(format_in), .rt_addr_in(rt_addr_in),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .imm_in(imm_in), .reg_write_in(reg_write_in),
    .wb_data(wb_data), .wb_addr(wb_addr), .wb_en(wb_en),
    .fwd_data(fwd_data), .fwd_addr(fwd_addr), .fwd_en(fwd_en),
    .op(op), .format(format), .rt_addr(rt_addr), .ra(ra), .rb(rb), .imm(imm), .reg_write(reg_write)
  );

  function automatic logic [127:0] sel(input logic [6:0] s);
    if (fwd_en && fwd_addr == s) return fwd_data;
    if (wb_en && wb_addr == s) return wb_data;
    return mregs[s];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle();
    reset = 0; stall = 0; flush = 0; reg_write_in = 0; wb_en = 0; fwd_en = 0;
    op_in = 0; format_in = 0; rt_addr_in = 0; ra_addr = 0; rb_addr = 0; imm_in = 0;
    wb_data = 0; wb_addr = 0; fwd_data = 0; fwd_addr = 0;
  endtask

  // Computes the expected outputs for the currently driven inputs, queues them, then clocks once.
  task automatic step();
    out_t x;
    if (reset) begin
      x = '0; m_ra = 0; m_rb = 0;
      for (int i = 0; i < 128; i++) mregs[i] = '0;
    end else if (flush) begin
      x = '0; m_ra = 0; m_rb = 0;
    end else if (stall) begin
      x = m_out; x.ra = sel(m_ra); x.rb = sel(m_rb);
    end else begin
      x = {op_in, format_in, rt_addr_in, sel(ra_addr), sel(rb_addr), imm_in, reg_write_in};
      m_ra = ra_addr; m_rb = rb_addr;
    end
    if (wb_en && !reset) mregs[wb_addr] = wb_data;
    m_out = x;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1; step(); void'(sb.pop_front()); step();
    e = sb.pop_front(); checks++;
    if (dout !== e || dout !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected %h", dout, e); end
    idle(); ra_addr = 17; rb_addr = 100; op_in = 11'h7ff; step();
    e = sb.pop_front(); checks++;
    if (dout !== e || ra !== '0 || rb !== '0) begin errors++; $display("FAIL reset_idle_read: got %h expected %h", dout, e); end
  endtask

  task automatic test_write_read();
    logic [127:0] v = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
    idle(); wb_en = 1; wb_addr = 5; wb_data = v; step(); void'(sb.pop_front());
    idle(); ra_addr = 5; op_in = 11'b00011001000; rt_addr_in = 9; reg_write_in = 1; step();
    e = sb.pop_front(); checks++;
    if (dout !== e) begin errors++; $display("FAIL write_read_model: got %h expected %h", dout, e); end
    checks++;
    if (ra !== v || op !== 11'b00011001000 || rt_addr !== 7'd9 || reg_write !== 1'b1 || format !== 3'd0)
      begin errors++; $display("FAIL write_read_fields: ra %h op %b rt %0d rw %b, required ra %h op 00011001000 rt 9 rw 1", ra, op, rt_addr, reg_write, v); end
  endtask

  task automatic test_bypass();
    logic [127:0] a = rnd128(), b = rnd128(), c = rnd128();
    idle(); wb_en = 1; wb_addr = 3; wb_data = a; step(); void'(sb.pop_front());
    idle(); wb_en = 1; wb_addr = 3; wb_data = b; fwd_en = 1; fwd_addr = 3; fwd_data = c; ra_addr = 3; rb_addr = 3; step();
    e = sb.pop_front(); checks++;
    if (dout !== e || ra !== c || rb !== c) begin errors++; $display("FAIL bypass_fwd_wins: ra %h rb %h required %h", ra, rb, c); end
    fwd_en = 0; step();
    e = sb.pop_front(); checks++;
    if (dout !== e || ra !== b || rb !== b) begin errors++; $display("FAIL bypass_wb: ra %h rb %h required %h", ra, rb, b); end
    idle(); ra_addr = 3; rb_addr = 5; step();
    e = sb.pop_front(); checks++;
    if (dout !== e || ra !== b) begin errors++; $display("FAIL bypass_array: ra %h required %h", ra, b); end
  endtask

  task automatic test_stall_refresh();
    idle(); ra_addr = 7; rb_addr = 5; op_in = 11'h123; rt_addr_in = 12; imm_in = 18'h2abcd; reg_write_in = 1; step();
    e = sb.pop_front(); checks++;
    if (dout !== e || ra !== '0) begin errors++; $display("FAIL stall_issue: got %h expected %h", dout, e); end
    for (int i = 0; i < 3; i++) begin
      idle(); stall = 1; op_in = 11'h555; rt_addr_in = 30; imm_in = 18'h11111; ra_addr = 5; reg_write_in = 0;
      if (i == 1) begin wb_en = 1; wb_addr = 7; wb_data = 128'hFFFF; end
      step();
      e = sb.pop_front(); checks++;
      if (dout !== e || op !== 11'h123 || rt_addr !== 7'd12 || imm !== 18'h2abcd || reg_write !== 1'b1 ||
          ra !== ((i == 0) ? 128'h0 : 128'hFFFF))
        begin errors++; $display("FAIL stall_cycle%0d: got %h expected %h", i, dout, e); end
    end
  endtask

  task automatic test_flush_over_stall();
    logic [127:0] d = rnd128();
    idle(); ra_addr = 5; op_in = 11'h0f0; rt_addr_in = 2; imm_in = 18'h3; reg_write_in = 1; step(); void'(sb.pop_front());
    idle(); stall = 1; flush = 1; op_in = 11'h7; wb_en = 1; wb_addr = 20; wb_data = d; step();
    e = sb.pop_front(); checks++;
    if (dout !== e || dout !== '0) begin errors++; $display("FAIL flush_nop: got %h expected 0", dout); end
    idle(); ra_addr = 20; step();
    e = sb.pop_front(); checks++;
    if (dout !== e || ra !== d) begin errors++; $display("FAIL flush_wb_lands: ra %h required %h", ra, d); end
  endtask

  task automatic test_reset_mid_stall();
    logic [127:0] x = rnd128();
    idle(); wb_en = 1; wb_addr = 4; wb_data = x; step(); void'(sb.pop_front());
    idle(); ra_addr = 4; op_in = 11'h3c; rt_addr_in = 8; imm_in = 18'h77; reg_write_in = 1; step(); void'(sb.pop_front());
    idle(); stall = 1; step(); void'(sb.pop_front());
    idle(); stall = 1; reset = 1; wb_en = 1; wb_addr = 4; wb_data = rnd128(); step();
    e = sb.pop_front(); checks++;
    if (dout !== e || dout !== '0) begin errors++; $display("FAIL reset_mid_stall: got %h expected 0", dout); end
    idle(); ra_addr = 4; rb_addr = 5; step();
    e = sb.pop_front(); checks++;
    if (dout !== e || ra !== '0 || rb !== '0) begin errors++; $display("FAIL reset_clears_regs: ra %h rb %h required 0", ra, rb); end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 300; n++) begin
      reset = ($urandom_range(0, 99) == 0); stall = ($urandom_range(0, 3) == 0); flush = ($urandom_range(0, 9) == 0);
      op_in = 11'($urandom); format_in = 3'($urandom); rt_addr_in = 7'($urandom); imm_in = 18'($urandom);
      reg_write_in = 1'($urandom); ra_addr = 7'($urandom_range(0, 7)); rb_addr = 7'($urandom_range(0, 7));
      wb_en = 1'($urandom); wb_addr = 7'($urandom_range(0, 7)); wb_data = rnd128();
      fwd_en = 1'($urandom); fwd_addr = 7'($urandom_range(0, 7)); fwd_data = rnd128();
      step();
      e = sb.pop_front(); checks++;
      if (dout !== e) begin errors++; $display("FAIL random_%0d: got %h expected %h", n, dout, e); end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_stall_refresh();
    test_flush_over_stall();
    test_reset_mid_stall();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
